neureka_infeat_loader: RTL and testbench

Upstream stage of the input feature buffer. Converts the streamer's byte-misaligned memory beats into one aligned BLOCK_SIZE-byte pixel slice per handshake. Emits zero slices for implicitly padded pixel positions without consuming memory data, and signals completion of a load of load_len pixels. Its output feeds the buffer's feature write port in LOAD phase.

---
 rtl/neureka_infeat_loader.sv | 164 ++++++++++++++++
 tb/tb_neureka_infeat_loader.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neureka_infeat_loader.sv
// Input feature loader: realigns byte-misaligned memory beats into one
// BLOCK_SIZE-byte pixel slice per output handshake, inserting zero slices for padding.
//
// state | meaning
// IDLE  | waiting for start_i, config latched on start
// PRIME | fetching the first beat of a misaligned load into the hold register
// RUN   | emitting pixels 0..load_len-1 through the single-entry output register
// DONE  | one-cycle completion pulse, then back to IDLE
module neureka_infeat_loader #(
   parameter int unsigned BLOCK_SIZE = 32,
   parameter int unsigned NW         = 64,
   parameter int unsigned LW         = $clog2(NW) + 1,
   parameter int unsigned OW         = $clog2(BLOCK_SIZE)
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    enable_i,
   input  logic                    clear_i,
   input  logic                    start_i,
   input  logic [LW-1:0]           load_len_i,
   input  logic [OW-1:0]           offset_i,
   input  logic [NW-1:0]           pad_mask_i,
   input  logic [BLOCK_SIZE*8-1:0] in_data_i,
   input  logic                    in_valid_i,
   output logic                    in_ready_o,
   output logic [BLOCK_SIZE*8-1:0] out_data_o,
   output logic                    out_valid_o,
   input  logic                    out_ready_i,
   output logic                    busy_o,
   output logic                    done_o
);

   localparam int unsigned DW = BLOCK_SIZE * 8;
   localparam int unsigned IW = $clog2(NW);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PRIME,
      ST_RUN,
      ST_DONE
   } state_t;

   state_t          state_q,     state_d;
   logic [LW-1:0]   len_q,       len_d;
   logic [OW-1:0]   off_q,       off_d;
   logic [NW-1:0]   pad_q,       pad_d;
   logic [LW-1:0]   pix_cnt_q,   pix_cnt_d;
   logic [DW-1:0]   hold_q,      hold_d;
   logic [DW-1:0]   out_data_q,  out_data_d;
   logic            out_valid_q, out_valid_d;

   logic            adv;
   logic            pop;
   logic            pix_left;
   logic            cur_pad;
   logic            in_ready;
   logic [2*DW-1:0] cat_w;
   logic [DW-1:0]   slice;

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      off_d       = off_q;
      pad_d       = pad_q;
      pix_cnt_d   = pix_cnt_q;
      hold_d      = hold_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      in_ready    = 1'b0;

      adv      = !out_valid_q || out_ready_i;
      pop      = out_valid_q && out_ready_i;
      pix_left = (pix_cnt_q < len_q);
      cur_pad  = pad_q[pix_cnt_q[IW-1:0]];

      // Slice starts off_q bytes into the held beat and spills into the new one.
      cat_w = {in_data_i, hold_q} >> {off_q, 3'b000};
      slice = (off_q == '0) ? in_data_i : cat_w[DW-1:0];

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               len_d     = load_len_i;
               off_d     = offset_i;
               pad_d     = pad_mask_i;
               pix_cnt_d = '0;
               if (load_len_i == '0) begin
                  state_d = ST_DONE;
               end else if (offset_i != '0) begin
                  state_d = ST_PRIME;
               end else begin
                  state_d = ST_RUN;
               end
            end
         end
         ST_PRIME: begin
            in_ready = 1'b1;
            if (in_valid_i) begin
               hold_d  = in_data_i;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (pop) begin
               out_valid_d = 1'b0;
            end
            if (pix_left && adv) begin
               if (cur_pad) begin
                  out_data_d  = '0;
                  out_valid_d = 1'b1;
                  pix_cnt_d   = pix_cnt_q + LW'(1);
               end else begin
                  in_ready = 1'b1;
                  if (in_valid_i) begin
                     out_data_d  = slice;
                     out_valid_d = 1'b1;
                     hold_d      = in_data_i;
                     pix_cnt_d   = pix_cnt_q + LW'(1);
                  end
               end
            end
            // All pixels issued and the last one leaves the output register.
            if (pop && !pix_left) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni || clear_i) begin
         state_q     <= ST_IDLE;
         len_q       <= '0;
         off_q       <= '0;
         pad_q       <= '0;
         pix_cnt_q   <= '0;
         hold_q      <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else if (enable_i) begin
         state_q     <= state_d;
         len_q       <= len_d;
         off_q       <= off_d;
         pad_q       <= pad_d;
         pix_cnt_q   <= pix_cnt_d;
         hold_q      <= hold_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready_o  = enable_i && in_ready;
   assign out_valid_o = enable_i && out_valid_q;
   assign out_data_o  = out_data_q;
   assign busy_o      = (state_q != ST_IDLE);
   assign done_o      = (state_q == ST_DONE);

endmodule

// File: tb/tb_neureka_infeat_loader.sv
// Scoreboard bench for the input feature loader: a byte-stream model predicts
// every slice; a monitor checks output handshakes, stalls and done timing.
module tb_neureka_infeat_loader;

   localparam int BS = 32;
   localparam int NW = 64;
   localparam int LW = $clog2(NW) + 1;
   localparam int OW = $clog2(BS);
   localparam int DW = BS * 8;

   logic          clk = 1'b0;
   logic          rst_ni;
   logic          enable_i;
   logic          clear_i;
   logic          start_i;
   logic [LW-1:0] load_len_i;
   logic [OW-1:0] offset_i;
   logic [NW-1:0] pad_mask_i;
   logic [DW-1:0] in_data_i;
   logic          in_valid_i;
   logic          in_ready_o;
   logic [DW-1:0] out_data_o;
   logic          out_valid_o;
   logic          out_ready_i;
   logic          busy_o;
   logic          done_o;

   neureka_infeat_loader #(.BLOCK_SIZE(BS), .NW(NW)) dut (
      .clk_i(clk), .rst_ni(rst_ni), .enable_i(enable_i), .clear_i(clear_i),
      .start_i(start_i), .load_len_i(load_len_i), .offset_i(offset_i),
      .pad_mask_i(pad_mask_i), .in_data_i(in_data_i), .in_valid_i(in_valid_i),
      .in_ready_o(in_ready_o), .out_data_o(out_data_o), .out_valid_o(out_valid_o),
      .out_ready_i(out_ready_i), .busy_o(busy_o), .done_o(done_o)
   );

   always #5 clk = ~clk;

   int            n_cmp = 0;
   int            n_fail = 0;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] beat_q[$];
   int            beats_acc = 0;
   int            out_cnt = 0;
   int            done_cnt = 0;
   int            cyc = 0;
   int            last_hs = 0;
   int            cur_len = 0;
   bit            mon_off = 1'b1;
   bit            en_hold = 1'b0;
   bit            en_rand = 1'b0;
   bit            in_rand = 1'b0;
   int            out_mode = 0;
   logic [3:0]    rdy_pat = 4'b1001;
   int            pat_i = 0;
   bit            prev_stall = 1'b0;
   bit            prev_done = 1'b0;
   logic [DW-1:0] prev_data = '0;

   task automatic chk(input bit ok, input string nm, input logic [DW-1:0] act,
                      input logic [DW-1:0] req);
      n_cmp++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", nm, act, req);
      end
   endtask

   // Stimulus drivers run 1 time unit after the falling edge, after the main sequence.
   always begin
      @(negedge clk);
      #1;
      enable_i    = en_hold ? 1'b1 : (en_rand ? ($urandom_range(0, 7) != 0) : 1'b1);
      in_valid_i  = (beat_q.size() > 0) && (in_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
      in_data_i   = (beat_q.size() > 0) ? beat_q[0] : {8{$urandom}};
      case (out_mode)
         0:       out_ready_i = 1'b1;
         1:       out_ready_i = $urandom_range(0, 1) == 1;
         default: out_ready_i = rdy_pat[3 - (pat_i % 4)];
      endcase
      pat_i++;
   end

   // Monitor: samples just before each rising edge.
   always begin
      @(negedge clk);
      #4;
      if (mon_off) begin
         prev_stall = 1'b0;
         prev_done  = 1'b0;
      end else if (enable_i) begin
         cyc++;
         if (prev_stall) begin
            chk(out_valid_o && out_data_o == prev_data, "stall_hold", out_data_o, prev_data);
         end
         if (out_valid_o && !out_ready_i) begin
            chk(!in_ready_o, "in_ready_during_stall", DW'(in_ready_o), '0);
         end
         prev_stall = out_valid_o && !out_ready_i;
         prev_data  = out_data_o;
         if (out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
               chk(1'b0, "unexpected_slice", out_data_o, '0);
            end else begin
               logic [DW-1:0] e;
               e = exp_q.pop_front();
               chk(out_data_o === e, "slice_data", out_data_o, e);
            end
            out_cnt++;
            last_hs = cyc;
         end
         if (in_valid_i && in_ready_o) begin
            beats_acc++;
            if (beat_q.size() > 0) void'(beat_q.pop_front());
         end
         if (done_o) begin
            done_cnt++;
            if (cur_len != 0) begin
               chk(cyc == last_hs + 1, "done_timing", DW'(cyc), DW'(last_hs + 1));
            end
            chk(!prev_done, "done_width", DW'(prev_done), '0);
         end
         prev_done = done_o;
      end
   end

   // Reference model: slices are windows into the concatenated byte stream.
   task automatic prep_load(input int len, input int off, input logic [NW-1:0] pad,
                            input int pat, output int nb);
      logic [7:0]    stream[$];
      logic [DW-1:0] beat;
      logic [DW-1:0] s;
      int            nreal;
      int            r;
      nreal = 0;
      for (int k = 0; k < len; k++) if (!pad[k]) nreal++;
      nb = (len == 0) ? 0 : nreal + ((off != 0) ? 1 : 0);
      for (int n = 0; n < nb; n++) begin
         for (int b = 0; b < BS; b++) begin
            logic [7:0] v;
            if (pat == 1)      v = 8'(16 * n + b);
            else if (pat == 2) v = 8'((n << 5) | b);
            else               v = 8'($urandom);
            stream.push_back(v);
            beat[b*8 +: 8] = v;
         end
         beat_q.push_back(beat);
      end
      r = 0;
      for (int k = 0; k < len; k++) begin
         s = '0;
         if (!pad[k]) begin
            for (int j = 0; j < BS; j++) s[j*8 +: 8] = stream[off + r * BS + j];
            r++;
         end
         exp_q.push_back(s);
      end
      beats_acc = 0;
      cur_len   = len;
   endtask

   task automatic start_load(input int len, input int off, input logic [NW-1:0] pad);
      @(negedge clk);
      en_hold    = 1'b1;
      start_i    = 1'b1;
      load_len_i = LW'(len);
      offset_i   = OW'(off);
      pad_mask_i = pad;
      @(negedge clk);
      en_hold    = 1'b0;
      start_i    = 1'b0;
      load_len_i = LW'($urandom);
      offset_i   = OW'($urandom);
      pad_mask_i = {$urandom, $urandom};
   endtask

   task automatic do_load(input int len, input int off, input logic [NW-1:0] pad,
                          input int pat);
      int nb;
      int d0;
      bit seen;
      prep_load(len, off, pad, pat, nb);
      d0 = done_cnt;
      start_load(len, off, pad);
      seen = 1'b0;
      for (int i = 0; i < 3000 && !seen; i++) begin
         @(negedge clk);
         seen = (done_cnt != d0);
      end
      chk(seen, "done_timeout", DW'(seen), DW'(1));
      chk(beats_acc == nb, "beats_consumed", DW'(beats_acc), DW'(nb));
      chk(exp_q.size() == 0, "slices_left", DW'(exp_q.size()), '0);
      exp_q.delete();
      beat_q.delete();
   endtask

   task automatic check_idle_outputs(input string tag);
      chk(!in_ready_o, {tag, "_in_ready"}, DW'(in_ready_o), '0);
      chk(!out_valid_o, {tag, "_out_valid"}, DW'(out_valid_o), '0);
      chk(out_data_o == '0, {tag, "_out_data"}, out_data_o, '0);
      chk(!busy_o, {tag, "_busy"}, DW'(busy_o), '0);
      chk(!done_o, {tag, "_done"}, DW'(done_o), '0);
   endtask

   task automatic abort_test(input bit use_rst);
      int  nb;
      int  o0;
      bit  got;
      out_mode = 0; in_rand = 1'b0; en_rand = 1'b0;
      prep_load(6, 0, '0, 0, nb);
      o0 = out_cnt;
      start_load(6, 0, '0);
      got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         got = (out_cnt >= o0 + 2);
      end
      chk(got, "abort_wait_timeout", DW'(got), DW'(1));
      mon_off = 1'b1;
      if (use_rst) rst_ni = 1'b0;
      else         clear_i = 1'b1;
      @(negedge clk);
      rst_ni  = 1'b1;
      clear_i = 1'b0;
      exp_q.delete();
      beat_q.delete();
      #4;
      check_idle_outputs(use_rst ? "after_rst" : "after_clear");
      mon_off = 1'b0;
      do_load(2, 0, '0, 0);
   endtask

   initial begin
      rst_ni = 1'b0; enable_i = 1'b1; clear_i = 1'b0; start_i = 1'b0;
      load_len_i = '0; offset_i = '0; pad_mask_i = '0;
      in_data_i = '0; in_valid_i = 1'b0; out_ready_i = 1'b1;
      repeat (3) @(negedge clk);
      rst_ni = 1'b1;
      #4;
      check_idle_outputs("reset");
      mon_off = 1'b0;

      do_load(4, 0, '0, 1);
      do_load(3, 5, '0, 2);
      do_load(5, 3, 64'b10010, 2);

      out_mode = 2;
      do_load(6, 0, '0, 0);
      out_mode = 0;

      // Zero-length load: single-cycle busy with done, never requests a beat.
      cur_len = 0;
      start_load(0, 7, '0);
      #4;
      chk(done_o, "zlen_done", DW'(done_o), DW'(1));
      chk(busy_o, "zlen_busy", DW'(busy_o), DW'(1));
      chk(!in_ready_o, "zlen_in_ready", DW'(in_ready_o), '0);
      @(negedge clk);
      #4;
      chk(!done_o, "zlen_done_end", DW'(done_o), '0);
      chk(!busy_o, "zlen_busy_end", DW'(busy_o), '0);
      chk(!in_ready_o, "zlen_in_ready_end", DW'(in_ready_o), '0);

      abort_test(1'b0);
      abort_test(1'b1);

      do_load(1, 31, 64'b1, 0);
      do_load(64, 0, '0, 0);
      do_load(64, 31, '0, 0);

      for (int t = 0; t < 20; t++) begin
         int            len;
         int            off;
         logic [NW-1:0] pad;
         len      = (t % 5 == 0) ? 64 : $urandom_range(0, 64);
         off      = $urandom_range(0, 31);
         pad      = {$urandom, $urandom} & {$urandom, $urandom};
         out_mode = $urandom_range(0, 2);
         in_rand  = $urandom_range(0, 1) == 1;
         en_rand  = $urandom_range(0, 1) == 1;
         do_load(len, off, pad, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
